// File: rtl/aes_round_sequencer.sv
// Control FSM that walks the AES vector datapath through one cipher or inverse-cipher block,
// issuing micro-ops with round-key indices under a valid/ready handshake.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int RK_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            decrypt,
    input  logic            abort,
    input  logic            op_ready,
    output logic            op_valid,
    output logic [2:0]      op_code,
    output logic [RK_W-1:0] rk_idx,
    output logic [RK_W-1:0] round,
    output logic            state_ld,
    output logic            state_st,
    output logic            busy,
    output logic            done
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_ADDRK      = 3'd1;
    localparam logic [2:0] OP_SUBB       = 3'd2;
    localparam logic [2:0] OP_SHROWS     = 3'd3;
    localparam logic [2:0] OP_MIXCOL     = 3'd4;
    localparam logic [2:0] OP_INV_SUBB   = 3'd5;
    localparam logic [2:0] OP_INV_SHROWS = 3'd6;
    localparam logic [2:0] OP_INV_MIXCOL = 3'd7;

    localparam logic [RK_W-1:0] NR  = RK_W'(NUM_ROUNDS);
    localparam logic [RK_W-1:0] ONE = RK_W'(1);

    state_t          state, state_nxt;
    // step counts rounds in cipher order (0..Nr) for both directions; the inverse
    // direction maps it back to its own round/key numbering in the decoder below.
    logic [RK_W-1:0] step, step_nxt;
    logic [1:0]      opi, opi_nxt;
    logic            dec_q, dec_nxt;

    logic [2:0]      cur_op;
    logic [RK_W-1:0] cur_rk;
    logic [RK_W-1:0] cur_rnd;
    logic            last_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            step  <= '0;
            opi   <= '0;
            dec_q <= 1'b0;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
            opi   <= opi_nxt;
            dec_q <= dec_nxt;
        end
    end

    always_comb begin
        cur_op  = OP_NOP;
        cur_rk  = '0;
        cur_rnd = '0;
        if (!dec_q) begin
            cur_rnd = step;
            if (step == '0) begin
                cur_op = OP_ADDRK;
            end else begin
                case (opi)
                    2'd0:    cur_op = OP_SUBB;
                    2'd1:    cur_op = OP_SHROWS;
                    2'd2:    cur_op = (step == NR) ? OP_ADDRK : OP_MIXCOL;
                    default: cur_op = OP_ADDRK;
                endcase
                if (cur_op == OP_ADDRK) cur_rk = step;
            end
        end else begin
            cur_rnd = (step == '0) ? '0 : NR - step;
            if (step == '0) begin
                cur_op = OP_ADDRK;
                cur_rk = NR;
            end else begin
                case (opi)
                    2'd0:    cur_op = OP_INV_SHROWS;
                    2'd1:    cur_op = OP_INV_SUBB;
                    2'd2:    cur_op = OP_ADDRK;
                    default: cur_op = OP_INV_MIXCOL;
                endcase
                if (cur_op == OP_ADDRK) cur_rk = NR - step;
            end
        end
    end

    // The final round has only three ops in either direction, ending at slot 2.
    assign last_op = (step == NR) && (opi == 2'd2);

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        opi_nxt   = opi;
        dec_nxt   = dec_q;
        op_valid  = 1'b0;
        op_code   = OP_NOP;
        rk_idx    = '0;
        round     = '0;
        state_ld  = 1'b0;
        state_st  = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = S_LOAD;
                    dec_nxt   = decrypt;
                    step_nxt  = '0;
                    opi_nxt   = '0;
                end
            end
            S_LOAD: begin
                state_ld  = 1'b1;
                state_nxt = abort ? S_IDLE : S_ISSUE;
            end
            S_ISSUE: begin
                op_valid = 1'b1;
                op_code  = cur_op;
                rk_idx   = cur_rk;
                round    = cur_rnd;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (op_ready) begin
                    if (last_op) begin
                        state_nxt = S_STORE;
                    end else if (step == '0 || opi == 2'd3) begin
                        step_nxt = step + ONE;
                        opi_nxt  = '0;
                    end else begin
                        opi_nxt = opi + 2'd1;
                    end
                end
            end
            S_STORE: begin
                state_st  = 1'b1;
                state_nxt = abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: a table of runs (direction, backpressure, aborts)
// checked against a spec-derived micro-op stream, plus reset and Nr=14 sequences.
module tb_aes_round_sequencer;
    localparam logic [2:0] OP_ADDRK      = 3'd1;
    localparam logic [2:0] OP_SUBB       = 3'd2;
    localparam logic [2:0] OP_SHROWS     = 3'd3;
    localparam logic [2:0] OP_MIXCOL     = 3'd4;
    localparam logic [2:0] OP_INV_SUBB   = 3'd5;
    localparam logic [2:0] OP_INV_SHROWS = 3'd6;
    localparam logic [2:0] OP_INV_MIXCOL = 3'd7;
    localparam int W = 11;

    typedef struct {
        bit dec;
        int ready_pct;
        int abort_op;
        bit abort_store;
        bit busy_start;
    } run_t;

    logic clk, rst, start, decrypt, abort, op_ready, sel;

    logic       v10, ld10, st10, busy10, done10;
    logic [2:0] op10;
    logic [3:0] rk10, rnd10;
    logic       v14, ld14, st14, busy14, done14;
    logic [2:0] op14;
    logic [3:0] rk14, rnd14;

    logic       o_valid, o_ld, o_st, o_busy, o_done;
    logic [2:0] o_op;
    logic [3:0] o_rk, o_rnd;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    aes_round_sequencer #(.NUM_ROUNDS(10), .RK_W(4)) dut10 (
        .clk(clk), .rst(rst), .start(start & ~sel), .decrypt(decrypt), .abort(abort),
        .op_ready(op_ready), .op_valid(v10), .op_code(op10), .rk_idx(rk10), .round(rnd10),
        .state_ld(ld10), .state_st(st10), .busy(busy10), .done(done10)
    );

    aes_round_sequencer #(.NUM_ROUNDS(14), .RK_W(4)) dut14 (
        .clk(clk), .rst(rst), .start(start & sel), .decrypt(decrypt), .abort(abort),
        .op_ready(op_ready), .op_valid(v14), .op_code(op14), .rk_idx(rk14), .round(rnd14),
        .state_ld(ld14), .state_st(st14), .busy(busy14), .done(done14)
    );

    always_comb begin
        o_valid = sel ? v14    : v10;
        o_op    = sel ? op14   : op10;
        o_rk    = sel ? rk14   : rk10;
        o_rnd   = sel ? rnd14  : rnd10;
        o_ld    = sel ? ld14   : ld10;
        o_st    = sel ? st14   : st10;
        o_busy  = sel ? busy14 : busy10;
        o_done  = sel ? done14 : done10;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] op, input int rk, input int rnd);
        exp_q.push_back({op, 4'(rk), 4'(rnd)});
    endtask

    // Expected micro-op stream written straight from the AES round structure.
    task automatic build_stream(input int nr, input bit dec);
        exp_q.delete();
        if (!dec) begin
            push(OP_ADDRK, 0, 0);
            for (int r = 1; r < nr; r++) begin
                push(OP_SUBB, 0, r); push(OP_SHROWS, 0, r);
                push(OP_MIXCOL, 0, r); push(OP_ADDRK, r, r);
            end
            push(OP_SUBB, 0, nr); push(OP_SHROWS, 0, nr); push(OP_ADDRK, nr, nr);
        end else begin
            push(OP_ADDRK, nr, 0);
            for (int r = nr - 1; r >= 1; r--) begin
                push(OP_INV_SHROWS, 0, r); push(OP_INV_SUBB, 0, r);
                push(OP_ADDRK, r, r); push(OP_INV_MIXCOL, 0, r);
            end
            push(OP_INV_SHROWS, 0, 0); push(OP_INV_SUBB, 0, 0); push(OP_ADDRK, 0, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_zero"}, int'({o_valid, o_op, o_rk, o_rnd, o_ld, o_st, o_busy, o_done}), 0);
    endtask

    task automatic run(input int nr, input bit use14, input run_t t);
        int cyc = 0, hs_cnt = 0, last_hs = -1, ld_cyc = -1, st_cyc = -1, done_cyc = -1;
        int ld_cnt = 0, st_cnt = 0, done_cnt = 0, mix_cnt = 0, imix_cnt = 0, end_cyc = -1;
        bit aborted = 0, abort_now;
        logic [W-1:0] got;
        build_stream(nr, t.dec);
        @(negedge clk);
        sel = use14;
        start = 1'b1;
        decrypt = t.dec;
        op_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            decrypt = ~t.dec;
            if (t.busy_start && cyc == 5) start = 1'b1;
            if (cyc > 2000) begin
                chk("run_timeout", cyc, 2000);
                break;
            end
            if (aborted) chk("abort_busy", int'(o_busy), 0);
            if (!o_busy) begin
                end_cyc = cyc;
                chk("end_outputs", int'({o_valid, o_st, o_done}), 0);
                break;
            end
            if (cyc == 1) chk("ld_first", int'({o_ld, o_valid}), 2);
            if (o_ld)   begin ld_cnt++;   ld_cyc = cyc;   end
            if (o_st)   begin st_cnt++;   st_cyc = cyc;   end
            if (o_done) begin done_cnt++; done_cyc = cyc; end
            if (o_valid) begin
                got = {o_op, o_rk, o_rnd};
                if (hs_cnt < exp_q.size()) chk("op_stream", int'(got), int'(exp_q[hs_cnt]));
                else chk("extra_op", hs_cnt, exp_q.size() - 1);
                if (o_op == OP_MIXCOL) mix_cnt++;
                if (o_op == OP_INV_MIXCOL) imix_cnt++;
            end else begin
                chk("nop_when_idle", int'({o_op, o_rk, o_rnd}), 0);
            end
            op_ready = ($urandom_range(99) < 32'(t.ready_pct));
            abort_now = (o_valid && hs_cnt == t.abort_op) || (t.abort_store && o_st);
            if (abort_now) begin
                abort = 1'b1;
                op_ready = 1'b1;
                aborted = 1'b1;
            end
            if (o_valid && op_ready && !abort_now) begin
                hs_cnt++;
                last_hs = cyc;
            end
        end
        abort = 1'b0;
        start = 1'b0;
        chk("ld_count", ld_cnt, 1);
        chk("ld_cycle", ld_cyc, 1);
        if (aborted) begin
            chk("abort_no_done", done_cnt, 0);
            chk("abort_st_count", st_cnt, t.abort_store ? 1 : 0);
            if (!t.abort_store) chk("abort_hs_count", hs_cnt, t.abort_op);
        end else begin
            chk("hs_count", hs_cnt, 4 * nr);
            chk("st_after_last_hs", st_cyc, last_hs + 1);
            chk("done_after_st", done_cyc, st_cyc + 1);
            chk("done_count", done_cnt, 1);
            chk("st_count", st_cnt, 1);
            chk("idle_after_done", end_cyc, done_cyc + 1);
            if (t.ready_pct >= 100) chk("done_cycle", done_cyc, 4 * nr + 3);
            if (t.dec) begin
                chk("mixcol_in_inverse", mix_cnt, 0);
                if (t.ready_pct >= 100) chk("inv_mixcol_count", imix_cnt, nr - 1);
            end
        end
        // Any queued start would show up as busy again within a couple of cycles.
        repeat (3) @(negedge clk);
        chk("stays_idle", int'(o_busy), 0);
    endtask

    run_t runs[9];

    initial begin
        run_t r14;
        int dn;
        runs[0] = '{dec: 0, ready_pct: 100, abort_op: -1, abort_store: 0, busy_start: 1};
        runs[1] = '{dec: 1, ready_pct: 100, abort_op: -1, abort_store: 0, busy_start: 0};
        runs[2] = '{dec: 0, ready_pct: 50,  abort_op: -1, abort_store: 0, busy_start: 0};
        runs[3] = '{dec: 1, ready_pct: 50,  abort_op: -1, abort_store: 0, busy_start: 1};
        runs[4] = '{dec: 0, ready_pct: 100, abort_op: 17, abort_store: 0, busy_start: 0};
        runs[5] = '{dec: 0, ready_pct: 100, abort_op: -1, abort_store: 0, busy_start: 0};
        runs[6] = '{dec: 1, ready_pct: 100, abort_op: -1, abort_store: 1, busy_start: 0};
        runs[7] = '{dec: 0, ready_pct: 100, abort_op: 39, abort_store: 0, busy_start: 0};
        runs[8] = '{dec: 1, ready_pct: 100, abort_op: -1, abort_store: 0, busy_start: 0};

        rst = 1'b1; start = 1'b0; decrypt = 1'b0; abort = 1'b0; op_ready = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Abort while idle must block a simultaneous start.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", int'(o_busy), 0);

        // Reset in the middle of the op stream.
        start = 1'b1; op_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_issue_valid", int'(o_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_rst");
        rst = 1'b0;
        dn = 0;
        repeat (50) begin
            @(negedge clk);
            if (o_done || o_busy) dn++;
        end
        chk("no_done_after_rst", dn, 0);

        for (int i = 0; i < 9; i++) run(10, 1'b0, runs[i]);

        r14 = '{dec: 0, ready_pct: 100, abort_op: -1, abort_store: 0, busy_start: 0};
        run(14, 1'b1, r14);
        r14.dec = 1;
        run(14, 1'b1, r14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
